// File: rtl/bus_cycle_ctrl_pkg.sv
// Shared encodings for the 68030 bus-cycle terminator: decoder one-hot layouts,
// port-width / DSACK codes, state encoding and small decode helpers.
package bus_cycle_ctrl_pkg;

    localparam int unsigned FUNCTION_SELECTED_MAXPOS = 3;
    localparam int unsigned DEVICE_SELECTED_MAXPOS   = 14;
    localparam int unsigned PORT_WIDTH_WIDTH         = 2;
    localparam int unsigned WAIT_COUNT_WIDTH         = 4;
    localparam int unsigned TIMEOUT_WIDTH            = 8;
    localparam int unsigned VEC_COUNT_WIDTH          = 3;

    // function_decode one-hot outputs
    localparam logic [FUNCTION_SELECTED_MAXPOS-1:0] FUNCTION_NORMAL  = 3'b001;
    localparam logic [FUNCTION_SELECTED_MAXPOS-1:0] FUNCTION_INT_ACK = 3'b010;
    localparam logic [FUNCTION_SELECTED_MAXPOS-1:0] FUNCTION_FPU     = 3'b100;

    // device_decode one-hot bit positions
    localparam int unsigned DEVICE_NULL       = 0;
    localparam int unsigned DEVICE_ROM        = 1;
    localparam int unsigned DEVICE_QUART      = 2;
    localparam int unsigned DEVICE_SLOT0      = 3;
    localparam int unsigned DEVICE_SLOT1      = 4;
    localparam int unsigned DEVICE_SLOT2      = 5;
    localparam int unsigned DEVICE_SLOT3      = 6;
    localparam int unsigned DEVICE_IDE1       = 7;
    localparam int unsigned DEVICE_IDE3       = 8;
    localparam int unsigned DEVICE_ETH        = 9;
    localparam int unsigned DEVICE_REGISTER8  = 10;
    localparam int unsigned DEVICE_REGISTER16 = 11;
    localparam int unsigned DEVICE_REGISTER32 = 12;
    localparam int unsigned DEVICE_SIMM       = 13;

    localparam logic [PORT_WIDTH_WIDTH-1:0] PORT_WIDTH_NULL = 2'b00;
    localparam logic [PORT_WIDTH_WIDTH-1:0] PORT_WIDTH_BYTE = 2'b01;
    localparam logic [PORT_WIDTH_WIDTH-1:0] PORT_WIDTH_WORD = 2'b10;
    localparam logic [PORT_WIDTH_WIDTH-1:0] PORT_WIDTH_LONG = 2'b11;

    // {DSACK1,DSACK0}, active-high before pin inversion
    localparam logic [1:0] DSACK_NONE = 2'b00;
    localparam logic [1:0] DSACK_BYTE = 2'b01;
    localparam logic [1:0] DSACK_WORD = 2'b10;
    localparam logic [1:0] DSACK_LONG = 2'b11;

    typedef enum logic [2:0] {
        BUSCTRL_STATE_IDLE = 3'd0,
        BUSCTRL_STATE_WAIT = 3'd1,
        BUSCTRL_STATE_ACK  = 3'd2,
        BUSCTRL_STATE_HOLD = 3'd3,
        BUSCTRL_STATE_ERR  = 3'd4
    } busctrl_state_t;

    // Exactly one device bit set and it is not the unmapped slot
    function automatic logic device_valid(input logic [DEVICE_SELECTED_MAXPOS-1:0] dev);
        logic onehot;
        onehot = (dev != '0) &&
                 ((dev & (dev - DEVICE_SELECTED_MAXPOS'(1))) == '0);
        return onehot && !dev[DEVICE_NULL];
    endfunction

    function automatic logic [1:0] width_to_dsack(input logic [PORT_WIDTH_WIDTH-1:0] width);
        logic [1:0] ack;
        case (width)
            PORT_WIDTH_BYTE: ack = DSACK_BYTE;
            PORT_WIDTH_WORD: ack = DSACK_WORD;
            PORT_WIDTH_LONG: ack = DSACK_LONG;
            default:         ack = DSACK_NONE;
        endcase
        return ack;
    endfunction

endpackage

// File: rtl/bus_cycle_ctrl_wait_counter.sv
// bus_wait_counter: loadable wait-state down-counter with zero flag, plus a
// saturating bus-cycle timeout counter.
module bus_wait_counter
    import bus_cycle_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        load,
    input  logic [WAIT_COUNT_WIDTH-1:0] load_value,
    input  logic                        decrement,
    input  logic                        timeout_clear,
    input  logic                        timeout_run,
    output logic                        wait_zero,
    output logic                        timeout_last
);

    logic [WAIT_COUNT_WIDTH-1:0] wait_count;
    logic [TIMEOUT_WIDTH-1:0]    timeout_count;

    // Wait-state count: load on cycle latch, count down to zero and stop there
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_count <= '0;
        end else if (load) begin
            wait_count <= load_value;
        end else if (decrement && (wait_count != '0)) begin
            wait_count <= wait_count - WAIT_COUNT_WIDTH'(1);
        end
    end

    // Timeout count: cleared on latch, counts while unterminated, saturates at the limit
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timeout_count <= '0;
        end else if (timeout_clear) begin
            timeout_count <= '0;
        end else if (timeout_run && (timeout_count < TIMEOUT_WIDTH'(TIMEOUT_CYCLES))) begin
            timeout_count <= timeout_count + TIMEOUT_WIDTH'(1);
        end
    end

    assign wait_zero    = (wait_count == '0);
    // High on the clock whose count step reaches the limit
    assign timeout_last = (timeout_count >= TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/bus_cycle_ctrl.sv
// bus_cycle_ctrl: terminates every 68030 bus cycle from the decoder outputs.
// Sequences device wait states, drives DSACK to the port width, autovectors
// interrupt acknowledges, raises BERR on unmapped/timed-out cycles and owns
// the boot-time vector_fetched flag.
module bus_cycle_ctrl
    import bus_cycle_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned VECTOR_CYCLES  = 4,
    parameter int unsigned WS_ROM         = 3,
    parameter int unsigned WS_QUART       = 2,
    parameter int unsigned WS_SLOT        = 1,
    parameter int unsigned WS_DEFAULT     = 0
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                as,
    input  logic [FUNCTION_SELECTED_MAXPOS-1:0] function_selected,
    input  logic [DEVICE_SELECTED_MAXPOS-1:0]   device_selected,
    input  logic [PORT_WIDTH_WIDTH-1:0]         port_width,
    output logic [1:0]                          dsack,
    output logic                                avec,
    output logic                                berr,
    output logic                                vector_fetched,
    output logic                                cycle_active
);

    busctrl_state_t              state;
    logic                        as_meta;
    logic                        as_s;
    logic                        as_s_q;
    logic                        as_rise;
    logic [PORT_WIDTH_WIDTH-1:0] width_q;
    logic                        rom_q;
    logic                        int_ack_q;
    logic [VEC_COUNT_WIDTH-1:0]  vec_count;
    logic [WAIT_COUNT_WIDTH-1:0] ws_sel;
    logic [WAIT_COUNT_WIDTH-1:0] wait_load_value;
    logic                        wait_load;
    logic                        wait_decrement;
    logic                        wait_zero;
    logic                        timeout_run;
    logic                        timeout_last;

    // Two-flop synchroniser for the asynchronous strobe plus a delayed copy for edge detect
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            as_meta <= 1'b0;
            as_s    <= 1'b0;
            as_s_q  <= 1'b0;
        end else begin
            as_meta <= as;
            as_s    <= as_meta;
            as_s_q  <= as_s;
        end
    end

    assign as_rise = as_s && !as_s_q;

    // Device to wait-state mapping, and counter controls
    always_comb begin
        ws_sel = WAIT_COUNT_WIDTH'(WS_DEFAULT);
        if (device_selected[DEVICE_ROM]) begin
            ws_sel = WAIT_COUNT_WIDTH'(WS_ROM);
        end else if (device_selected[DEVICE_QUART]) begin
            ws_sel = WAIT_COUNT_WIDTH'(WS_QUART);
        end else if (|device_selected[DEVICE_ETH:DEVICE_SLOT0]) begin
            ws_sel = WAIT_COUNT_WIDTH'(WS_SLOT);
        end
        // WAIT exits on the zero flag and ACK adds one more clock, so load WS-1
        // to land dsack exactly WS+1 clocks after the latch.
        wait_load_value = (ws_sel == '0) ? '0 : ws_sel - WAIT_COUNT_WIDTH'(1);
        wait_load       = (state == BUSCTRL_STATE_IDLE) && as_rise;
        wait_decrement  = (state == BUSCTRL_STATE_WAIT);
        timeout_run     = (state == BUSCTRL_STATE_WAIT) ||
                          ((state == BUSCTRL_STATE_HOLD) && (dsack == DSACK_NONE) && !avec);
    end

    bus_wait_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_counter (
        .clock         (clock),
        .reset         (reset),
        .load          (wait_load),
        .load_value    (wait_load_value),
        .decrement     (wait_decrement),
        .timeout_clear (wait_load),
        .timeout_run   (timeout_run),
        .wait_zero     (wait_zero),
        .timeout_last  (timeout_last)
    );

    // Bus-cycle FSM with registered termination outputs and vector-fetch tracking
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= BUSCTRL_STATE_IDLE;
            dsack          <= DSACK_NONE;
            avec           <= 1'b0;
            berr           <= 1'b0;
            vector_fetched <= 1'b0;
            cycle_active   <= 1'b0;
            width_q        <= PORT_WIDTH_NULL;
            rom_q          <= 1'b0;
            int_ack_q      <= 1'b0;
            vec_count      <= '0;
        end else begin
            case (state)
                BUSCTRL_STATE_IDLE: begin
                    if (as_rise) begin
                        cycle_active <= 1'b1;
                        width_q      <= port_width;
                        rom_q        <= device_selected[DEVICE_ROM] &&
                                        (function_selected == FUNCTION_NORMAL);
                        int_ack_q    <= (function_selected == FUNCTION_INT_ACK);
                        if (function_selected == FUNCTION_INT_ACK) begin
                            state <= BUSCTRL_STATE_ACK;
                        end else if (function_selected == FUNCTION_FPU) begin
                            state <= BUSCTRL_STATE_HOLD;
                        end else if ((function_selected == FUNCTION_NORMAL) &&
                                     device_valid(device_selected) &&
                                     (port_width != PORT_WIDTH_NULL)) begin
                            state <= (ws_sel == '0) ? BUSCTRL_STATE_ACK : BUSCTRL_STATE_WAIT;
                        end else begin
                            state <= BUSCTRL_STATE_ERR;
                            berr  <= 1'b1;
                        end
                    end
                end

                BUSCTRL_STATE_WAIT: begin
                    if (!as_s) begin
                        state        <= BUSCTRL_STATE_IDLE;
                        cycle_active <= 1'b0;
                    end else if (timeout_last) begin
                        state <= BUSCTRL_STATE_ERR;
                        berr  <= 1'b1;
                    end else if (wait_zero) begin
                        state <= BUSCTRL_STATE_ACK;
                    end
                end

                BUSCTRL_STATE_ACK: begin
                    if (!as_s) begin
                        state        <= BUSCTRL_STATE_IDLE;
                        cycle_active <= 1'b0;
                    end else begin
                        state <= BUSCTRL_STATE_HOLD;
                        if (int_ack_q) begin
                            avec <= 1'b1;
                        end else begin
                            dsack <= width_to_dsack(width_q);
                        end
                        if (rom_q && !vector_fetched) begin
                            vec_count <= vec_count + VEC_COUNT_WIDTH'(1);
                            if (vec_count == VEC_COUNT_WIDTH'(VECTOR_CYCLES - 1)) begin
                                vector_fetched <= 1'b1;
                            end
                        end
                    end
                end

                BUSCTRL_STATE_HOLD: begin
                    if (!as_s) begin
                        state        <= BUSCTRL_STATE_IDLE;
                        dsack        <= DSACK_NONE;
                        avec         <= 1'b0;
                        cycle_active <= 1'b0;
                    end else if (timeout_run && timeout_last) begin
                        state <= BUSCTRL_STATE_ERR;
                        berr  <= 1'b1;
                    end
                end

                BUSCTRL_STATE_ERR: begin
                    if (!as_s) begin
                        state        <= BUSCTRL_STATE_IDLE;
                        berr         <= 1'b0;
                        cycle_active <= 1'b0;
                    end
                end

                default: begin
                    state        <= BUSCTRL_STATE_IDLE;
                    dsack        <= DSACK_NONE;
                    avec         <= 1'b0;
                    berr         <= 1'b0;
                    cycle_active <= 1'b0;
                end
            endcase
        end
    end

endmodule
